// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter: shares the register-file write port between ALU and LSU and tracks outstanding loads.
// Define WB_ARB_ROUND_ROBIN_EN for round-robin tie-breaking; otherwise the LSU has fixed priority.
module regfile_wb_arbiter #(
   parameter int XLEN = 32
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            alu_valid_i,
   input  logic [4:0]      alu_sel_i,
   input  logic [XLEN-1:0] alu_data_i,
   output logic            alu_ready_o,
   input  logic            lsu_valid_i,
   input  logic [4:0]      lsu_sel_i,
   input  logic [XLEN-1:0] lsu_data_i,
   output logic            lsu_ready_o,
   input  logic            issue_i,
   input  logic [4:0]      issue_sel_i,
   input  logic [4:0]      rs1_sel_i,
   input  logic [4:0]      rs2_sel_i,
   output logic            rs1_busy_o,
   output logic            rs2_busy_o,
   output logic [4:0]      wr_sel_o,
   output logic [XLEN-1:0] wr_data_o
);

   logic            grant_alu_s;
   logic            grant_lsu_s;
   logic [4:0]      wr_sel_q;
   logic [4:0]      wr_sel_d;
   logic [XLEN-1:0] wr_data_q;
   logic [XLEN-1:0] wr_data_d;
   logic [31:0]     busy_q;
   logic [31:0]     busy_d;

`ifdef WB_ARB_ROUND_ROBIN_EN
   logic prio_lsu_q;
   logic prio_lsu_d;

   // On a tie the priority holder wins; any grant hands priority to the other side.
   assign grant_lsu_s = lsu_valid_i & (~alu_valid_i | prio_lsu_q);
   assign grant_alu_s = alu_valid_i & (~lsu_valid_i | ~prio_lsu_q);

   always_comb begin
      prio_lsu_d = prio_lsu_q;
      if (grant_lsu_s) begin
         prio_lsu_d = 1'b0;
      end else if (grant_alu_s) begin
         prio_lsu_d = 1'b1;
      end else begin
         prio_lsu_d = prio_lsu_q;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         prio_lsu_q <= 1'b1;
      end else begin
         prio_lsu_q <= prio_lsu_d;
      end
   end
`else
   assign grant_lsu_s = lsu_valid_i;
   assign grant_alu_s = alu_valid_i & ~lsu_valid_i;
`endif

   assign alu_ready_o = grant_alu_s;
   assign lsu_ready_o = grant_lsu_s;

   always_comb begin
      wr_sel_d  = 5'd0;
      wr_data_d = wr_data_q;
      if (grant_lsu_s) begin
         wr_sel_d  = lsu_sel_i;
         wr_data_d = lsu_data_i;
      end else if (grant_alu_s) begin
         wr_sel_d  = alu_sel_i;
         wr_data_d = alu_data_i;
      end else begin
         wr_sel_d  = 5'd0;
         wr_data_d = wr_data_q;
      end
   end

   // Clear is applied before set so a newly issued load to the same register survives.
   always_comb begin
      busy_d = busy_q;
      if (grant_lsu_s) begin
         busy_d[lsu_sel_i] = 1'b0;
      end else begin
         busy_d = busy_q;
      end
      if (issue_i && (issue_sel_i != 5'd0)) begin
         busy_d[issue_sel_i] = 1'b1;
      end else begin
         busy_d[issue_sel_i] = busy_d[issue_sel_i];
      end
      busy_d[0] = 1'b0;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_sel_q  <= 5'd0;
         wr_data_q <= {XLEN{1'b0}};
         busy_q    <= 32'd0;
      end else begin
         wr_sel_q  <= wr_sel_d;
         wr_data_q <= wr_data_d;
         busy_q    <= busy_d;
      end
   end

   assign wr_sel_o  = wr_sel_q;
   assign wr_data_o = wr_data_q;

   // A write still in the output register is not yet readable from the register file.
   assign rs1_busy_o = (rs1_sel_i != 5'd0) & (busy_q[rs1_sel_i] | (wr_sel_q == rs1_sel_i));
   assign rs2_busy_o = (rs2_sel_i != 5'd0) & (busy_q[rs2_sel_i] | (wr_sel_q == rs2_sel_i));

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios plus random traffic against a behavioural model.
module tb_regfile_wb_arbiter;

   localparam int XLEN = 32;
`ifdef WB_ARB_ROUND_ROBIN_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   logic            clk_i = 1'b0;
   logic            rst_i;
   logic            alu_valid_i;
   logic [4:0]      alu_sel_i;
   logic [XLEN-1:0] alu_data_i;
   logic            alu_ready_o;
   logic            lsu_valid_i;
   logic [4:0]      lsu_sel_i;
   logic [XLEN-1:0] lsu_data_i;
   logic            lsu_ready_o;
   logic            issue_i;
   logic [4:0]      issue_sel_i;
   logic [4:0]      rs1_sel_i;
   logic [4:0]      rs2_sel_i;
   logic            rs1_busy_o;
   logic            rs2_busy_o;
   logic [4:0]      wr_sel_o;
   logic [XLEN-1:0] wr_data_o;

   regfile_wb_arbiter #(.XLEN(XLEN)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .alu_valid_i(alu_valid_i), .alu_sel_i(alu_sel_i), .alu_data_i(alu_data_i), .alu_ready_o(alu_ready_o),
      .lsu_valid_i(lsu_valid_i), .lsu_sel_i(lsu_sel_i), .lsu_data_i(lsu_data_i), .lsu_ready_o(lsu_ready_o),
      .issue_i(issue_i), .issue_sel_i(issue_sel_i),
      .rs1_sel_i(rs1_sel_i), .rs2_sel_i(rs2_sel_i), .rs1_busy_o(rs1_busy_o), .rs2_busy_o(rs2_busy_o),
      .wr_sel_o(wr_sel_o), .wr_data_o(wr_data_o)
   );

   always #5 clk_i = ~clk_i;

   int n_total = 0;
   int n_bad   = 0;

   // Reference model state: what the register-file port and scoreboard should show now.
   bit [31:0]   m_busy;
   logic [4:0]  m_wr_sel;
   logic [31:0] m_wr_data;
   bit          m_turn_lsu;
   logic        obs_alu;
   logic        obs_lsu;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_busy     = 32'd0;
      m_wr_sel   = 5'd0;
      m_wr_data  = 32'd0;
      m_turn_lsu = 1'b1;
   endtask

   function automatic bit exp_busy(input logic [4:0] rs);
      if (rs == 5'd0) return 1'b0;
      return m_busy[rs] || (m_wr_sel == rs);
   endfunction

   task automatic idle_inputs();
      alu_valid_i = 1'b0; alu_sel_i = 5'd0; alu_data_i = 32'd0;
      lsu_valid_i = 1'b0; lsu_sel_i = 5'd0; lsu_data_i = 32'd0;
      issue_i = 1'b0; issue_sel_i = 5'd0;
      rs1_sel_i = 5'd0; rs2_sel_i = 5'd0;
   endtask

   task automatic run_cycle(input bit av, input logic [4:0] as, input logic [31:0] ad,
                            input bit lv, input logic [4:0] ls, input logic [31:0] ld,
                            input bit iv, input logic [4:0] is,
                            input logic [4:0] r1, input logic [4:0] r2,
                            output bit ga, output bit gl);
      @(negedge clk_i);
      alu_valid_i = av; alu_sel_i = as; alu_data_i = ad;
      lsu_valid_i = lv; lsu_sel_i = ls; lsu_data_i = ld;
      issue_i = iv; issue_sel_i = is;
      rs1_sel_i = r1; rs2_sel_i = r2;
      #1;
      if (av && lv) begin
         gl = RR ? m_turn_lsu : 1'b1;
         ga = !gl;
      end else begin
         gl = lv;
         ga = av;
      end
      check_val("alu_ready", 32'(alu_ready_o), 32'(ga));
      check_val("lsu_ready", 32'(lsu_ready_o), 32'(gl));
      check_val("wr_sel", 32'(wr_sel_o), 32'(m_wr_sel));
      check_val("wr_data", wr_data_o, m_wr_data);
      check_val("rs1_busy", 32'(rs1_busy_o), 32'(exp_busy(r1)));
      check_val("rs2_busy", 32'(rs2_busy_o), 32'(exp_busy(r2)));
      obs_alu = alu_ready_o;
      obs_lsu = lsu_ready_o;
      @(posedge clk_i);
      if (gl) begin
         m_wr_sel = ls; m_wr_data = ld; m_busy[ls] = 1'b0; m_turn_lsu = 1'b0;
      end else if (ga) begin
         m_wr_sel = as; m_wr_data = ad; m_turn_lsu = 1'b1;
      end else begin
         m_wr_sel = 5'd0;
      end
      if (iv && is != 5'd0) m_busy[is] = 1'b1;
      m_busy[0] = 1'b0;
      #1;
   endtask

   initial begin
      bit ga, gl;
      bit pa_v, pl_v;
      logic [4:0] pa_s, pl_s;
      logic [31:0] pa_d, pl_d;

      idle_inputs();
      rst_i = 1'b1;
      model_reset();
      @(negedge clk_i);
      rs1_sel_i = 5'd9;
      #1;
      check_val("rst_wr_sel", 32'(wr_sel_o), 32'd0);
      check_val("rst_wr_data", wr_data_o, 32'd0);
      check_val("rst_rs1_busy", 32'(rs1_busy_o), 32'd0);
      @(negedge clk_i);
      rst_i = 1'b0;

      // Tie straight out of reset: LSU holds priority first.
      run_cycle(1'b1, 5'd3, 32'h11, 1'b1, 5'd4, 32'h22, 1'b0, 5'd0, 5'd0, 5'd0, ga, gl);
      check_val("tie0_lsu", 32'(obs_lsu), 32'd1);
      check_val("tie0_alu", 32'(obs_alu), 32'd0);
      check_val("tie0_sel", 32'(wr_sel_o), 32'd4);
      run_cycle(1'b1, 5'd3, 32'h11, 1'b1, 5'd4, 32'h22, 1'b0, 5'd0, 5'd0, 5'd0, ga, gl);
      check_val("tie1_lsu", 32'(obs_lsu), RR ? 32'd0 : 32'd1);
      check_val("tie1_alu", 32'(obs_alu), RR ? 32'd1 : 32'd0);
      check_val("tie1_sel", 32'(wr_sel_o), RR ? 32'd3 : 32'd4);
      check_val("tie1_data", wr_data_o, RR ? 32'h11 : 32'h22);
      run_cycle(1'b1, 5'd3, 32'h11, 1'b1, 5'd4, 32'h22, 1'b0, 5'd0, 5'd0, 5'd0, ga, gl);
      check_val("tie2_lsu", 32'(obs_lsu), 32'd1);
      check_val("tie2_sel", 32'(wr_sel_o), 32'd4);

      run_cycle(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0, ga, gl);
      check_val("alu1_ready", 32'(obs_alu), 32'd1);
      check_val("alu1_sel", 32'(wr_sel_o), 32'd5);
      check_val("alu1_data", wr_data_o, 32'hDEADBEEF);
      run_cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0, ga, gl);
      check_val("alu1_sel_n2", 32'(wr_sel_o), 32'd0);
      check_val("alu1_data_hold", wr_data_o, 32'hDEADBEEF);

      run_cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 5'd9, 5'd0, ga, gl);
      check_val("sb_set", 32'(rs1_busy_o), 32'd1);
      run_cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h99, 1'b0, 5'd0, 5'd9, 5'd9, ga, gl);
      check_val("sb_clr_m1", 32'(rs1_busy_o), 32'd1);
      check_val("sb_clr_m1_rs2", 32'(rs2_busy_o), 32'd1);
      run_cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd9, 5'd9, ga, gl);
      check_val("sb_clr_m2", 32'(rs1_busy_o), 32'd0);

      run_cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 5'd9, 5'd0, ga, gl);
      run_cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h98, 1'b1, 5'd9, 5'd9, 5'd0, ga, gl);
      run_cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd9, 5'd0, ga, gl);
      run_cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd9, 5'd0, ga, gl);
      check_val("set_beats_clr", 32'(rs1_busy_o), 32'd1);

      run_cycle(1'b1, 5'd0, 32'h1234, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 5'd0, 5'd0, ga, gl);
      check_val("r0_wr_sel", 32'(wr_sel_o), 32'd0);
      check_val("r0_rs1", 32'(rs1_busy_o), 32'd0);

      // Asynchronous reset in the middle of a cycle with a write pending.
      run_cycle(1'b1, 5'd7, 32'h77, 1'b0, 5'd0, 32'd0, 1'b1, 5'd12, 5'd12, 5'd9, ga, gl);
      check_val("pre_rst_sel", 32'(wr_sel_o), 32'd7);
      check_val("pre_rst_busy", 32'(rs1_busy_o), 32'd1);
      #1;
      rst_i = 1'b1;
      #1;
      check_val("mid_rst_sel", 32'(wr_sel_o), 32'd0);
      check_val("mid_rst_data", wr_data_o, 32'd0);
      check_val("mid_rst_rs1", 32'(rs1_busy_o), 32'd0);
      check_val("mid_rst_rs2", 32'(rs2_busy_o), 32'd0);
      model_reset();
      idle_inputs();
      @(negedge clk_i);
      rst_i = 1'b0;

      pa_v = 1'b0; pl_v = 1'b0;
      pa_s = 5'd0; pl_s = 5'd0; pa_d = 32'd0; pl_d = 32'd0;
      for (int k = 0; k < 400; k++) begin
         if (!pa_v && ($urandom_range(1, 0) == 1)) begin
            pa_v = 1'b1; pa_s = 5'($urandom_range(15, 0)); pa_d = $urandom;
         end
         if (!pl_v && ($urandom_range(1, 0) == 1)) begin
            pl_v = 1'b1; pl_s = 5'($urandom_range(15, 0)); pl_d = $urandom;
         end
         run_cycle(pa_v, pa_s, pa_d, pl_v, pl_s, pl_d,
                   ($urandom_range(3, 0) == 0), 5'($urandom_range(15, 0)),
                   5'($urandom_range(15, 0)), 5'($urandom_range(15, 0)), ga, gl);
         if (ga) pa_v = 1'b0;
         if (gl) pl_v = 1'b0;
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Shares the single register-file write port between the ALU writeback path and the load/store unit (LSU). It also keeps a busy scoreboard of registers with outstanding loads, so decode can stall on RAW hazards. It sits between execute/memory and the register file. It drives the register file's write-select and write-data inputs through one registered stage.

## Interface
- XLEN, 32, data width of writeback values.
- clk_i  input  1  clock, rising edge.
- rst_i  input  1  asynchronous, active-high reset.
- alu_valid_i  input  1  ALU writeback request.
- alu_sel_i  input  5  ALU destination register.
- alu_data_i  input  XLEN  ALU result.
- alu_ready_o  output  1  ALU request accepted this cycle.
- lsu_valid_i  input  1  LSU load-data writeback request.
- lsu_sel_i  input  5  LSU destination register.
- lsu_data_i  input  XLEN  load data.
- lsu_ready_o  output  1  LSU request accepted this cycle.
- issue_i  input  1  a load is issued this cycle.
- issue_sel_i  input  5  destination of the issued load.
- rs1_sel_i, rs2_sel_i  input  5 each  decode source selects.
- rs1_busy_o, rs2_busy_o  output  1 each  source not yet readable; stall.
- wr_sel_o  output  5  register-file write select; 0 means no write.
- wr_data_o  output  XLEN  register-file write data.

## Operation
- **Acceptance:** a requester is accepted when its valid and ready are both high in the same cycle. Ready is combinational from valid and the priority state; it does not depend on data.
- **Single requester:** a lone valid requester is always granted.
- **Both valid:** only one is granted, chosen by the arbitration policy (see Configuration). The loser holds valid, sel and data stable until it is granted.
- **Output stage:** the accepted request's sel/data are registered into wr_sel_o/wr_data_o.
  - With no acceptance, wr_sel_o loads 0 and wr_data_o holds its value.
  - A request with sel = 0 is accepted normally. It produces wr_sel_o = 0, so no write takes place.
- **Scoreboard:** busy[31:1] register; bit 0 is constant 0.
  - Set: issue_i with issue_sel_i ≠ 0 sets busy[issue_sel_i].
  - Clear: an accepted LSU request clears busy[lsu_sel_i].
  - Simultaneous set and clear of the same register: set wins, because it is a newer load.
  - ALU acceptance never modifies busy.
- **Hazard outputs:**
  - rsN_busy_o = busy[rsN_sel_i] OR (wr_sel_o ≠ 0 AND wr_sel_o == rsN_sel_i).
  - The second term covers the write sitting in the output register, which the register file has not yet committed.
  - rsN_sel_i = 0 always yields 0.

## Timing
- **Reset values (asynchronous):**
  - wr_sel_o = 0, wr_data_o = 0.
  - busy = 0.
  - Round-robin priority = LSU.
  - alu_ready_o/lsu_ready_o follow valid and priority combinationally, but no acceptance is registered while rst_i is high.
- **Latency:** a request accepted in cycle N appears on wr_sel_o/wr_data_o in N+1. The register file commits it at the end of N+1, so it is readable from N+2.
- **Throughput:** one write per cycle. Back-to-back acceptances from the same or alternating requesters produce no bubbles.
- **Scoreboard timing:** a set from issue in cycle N shows on rsN_busy_o in N+1. A clear from LSU acceptance in N is masked by the wr_sel_o term in N+1, so busy stays high through N+1 and drops in N+2.
- **Reset mid-operation:** the pending output write and all busy bits are discarded immediately. Requesters must re-present after reset.

## Configuration
- WB_ARB_ROUND_ROBIN_EN defined:
  - One priority flip-flop, reset to LSU.
  - On a tie, the requester holding priority is granted.
  - After any grant, priority moves to the other requester.
  - A loser is therefore granted within 2 cycles.
- WB_ARB_ROUND_ROBIN_EN undefined:
  - Fixed priority: LSU always beats ALU; there is no priority flip-flop.
  - The ALU may starve while lsu_valid_i stays high.

## Test plan
- **Reset:** assert rst_i mid-cycle with wr_sel_o = 7 → wr_sel_o = 0, wr_data_o = 0 and all busy bits cleared immediately, without waiting for a clock edge.
- **Single ALU write:** alu_valid_i = 1, sel = 5, data = 0xDEADBEEF in cycle N → alu_ready_o = 1 in N; wr_sel_o = 5 and wr_data_o = 0xDEADBEEF in N+1; wr_sel_o = 0 in N+2.
- **Tie, round-robin:** both valid for 3 cycles (ALU sel 3 / 0x11, LSU sel 4 / 0x22) → grants LSU, ALU, then LSU again (the LSU re-presents). With the macro undefined → LSU every cycle and alu_ready_o = 0 throughout.
- **Scoreboard:**
  - issue_i with sel 9 in cycle N → rs1_busy_o = 1 for rs1_sel_i = 9 from N+1.
  - LSU write to 9 accepted in M → busy stays high in M+1 and is 0 in M+2.
- **Set beats clear:** issue_sel_i = 9 in the same cycle that an LSU write to 9 is accepted → busy[9] remains 1 afterwards.
- **Register 0:** ALU write with sel 0 → wr_sel_o = 0. issue_sel_i = 0 → no busy bit set. rs1_sel_i = 0 → rs1_busy_o = 0.
